// File: rtl/sram_wait_mem.sv
// Word-organised SRAM with zero-latency read, byte-lane write and a wait-state throttle on sram_rdy.
// Optional macro SRAM_RAW_FWD_EN: forward same-cycle write lanes onto rdata on a same-word collision.
module sram_wait_mem #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4096,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   raddr,
    input  logic [DATA_WIDTH/8-1:0] rsel,
    output logic [DATA_WIDTH-1:0]   rdata,
    input  logic                    we,
    input  logic [ADDR_WIDTH-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wsel,
    output logic                    sram_rdy,
    output logic                    addr_err,
    output logic                    stall_viol
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LANES = DATA_WIDTH / 8;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IDX_W-1:0]      ridx;
    logic [IDX_W-1:0]      widx;
    logic                  r_oor;
    logic                  w_oor;
    logic                  wr_ok;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic                  unused_bits;

    // Read lane select is informational only and byte offsets never reach the array.
    assign unused_bits = ^{rsel, raddr[1:0], waddr[1:0]};

    assign ridx  = raddr[IDX_W+1:2];
    assign widx  = waddr[IDX_W+1:2];
    assign r_oor = (raddr >> (IDX_W + 2)) != '0;
    assign w_oor = (waddr >> (IDX_W + 2)) != '0;
    assign wr_ok = we && !w_oor;

    always_comb begin
        rdata = '0;
        if (!r_oor) begin
            rdata = mem[ridx];
`ifdef SRAM_RAW_FWD_EN
            if (wr_ok && (widx == ridx)) begin
                for (int k = 0; k < LANES; k++) begin
                    if (wsel[k]) rdata[8*k +: 8] = wdata[8*k +: 8];
                end
            end
`endif
        end
    end

    // Array is not reset; a write coinciding with reset assertion is dropped.
    always_ff @(posedge HCLK) begin
        if (wr_ok && HRESETn) begin
            for (int k = 0; k < LANES; k++) begin
                if (wsel[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    // Strobes during throttle neither reload nor extend the count.
    always_comb begin
        cnt_nxt = cnt;
        if (cnt != 4'd0) begin
            cnt_nxt = cnt - 4'd1;
        end else if (re || we) begin
            cnt_nxt = WAIT_LD;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt        <= 4'd0;
            sram_rdy   <= 1'b1;
            addr_err   <= 1'b0;
            stall_viol <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            sram_rdy <= (cnt_nxt == 4'd0);
            addr_err <= (re && r_oor) || (we && w_oor);
            if ((re || we) && (cnt != 4'd0)) stall_viol <= 1'b1;
        end
    end
endmodule

// File: tb/tb_sram_wait_mem.sv
// Directed bench for sram_wait_mem: two instances (no throttle / 3 wait states) share one stimulus stream.
module tb_sram_wait_mem;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        re = 1'b0;
    logic [31:0] raddr = '0;
    logic [3:0]  rsel = 4'hF;
    logic        we = 1'b0;
    logic [31:0] waddr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wsel = '0;
    logic [31:0] rdata0, rdata3;
    logic        rdy0, rdy3, aerr0, aerr3, sv0, sv3;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_q[$];

    always #5 HCLK = ~HCLK;

    sram_wait_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4096), .WAIT_CYCLES(0)) u_dut0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .re(re), .raddr(raddr), .rsel(rsel), .rdata(rdata0),
        .we(we), .waddr(waddr), .wdata(wdata), .wsel(wsel),
        .sram_rdy(rdy0), .addr_err(aerr0), .stall_viol(sv0));

    sram_wait_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(4096), .WAIT_CYCLES(3)) u_dut3 (
        .HCLK(HCLK), .HRESETn(HRESETn), .re(re), .raddr(raddr), .rsel(rsel), .rdata(rdata3),
        .we(we), .waddr(waddr), .wdata(wdata), .wsel(wsel),
        .sram_rdy(rdy3), .addr_err(aerr3), .stall_viol(sv3));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with re asserted is a read response; compare against the scoreboard.
    always @(negedge HCLK) begin
        if (HRESETn && re) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rd_unexpected: read at 0x%08h with empty scoreboard", raddr);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                chk("rdata_w0", rdata0, e);
                chk("rdata_w3", rdata3, e);
            end
        end
    end

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        re = 1'b0;
        we = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        re = 1'b0;
        we = 1'b1; waddr = a; wdata = d; wsel = s;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e);
        we = 1'b0;
        re = 1'b1; raddr = a;
        exp_q.push_back(e);
        cyc();
        re = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] coll_exp;
        #12;
        chk("rst_rdy3", {31'd0, rdy3}, 32'd1);
        chk("rst_aerr3", {31'd0, aerr3}, 32'd0);
        chk("rst_sv3", {31'd0, sv3}, 32'd0);
        #3 HRESETn = 1'b1;
        cyc();

        // Throttle: write, let it drain, then re at t and a second re two cycles later.
        wr(32'h4, 32'hCAFE_F00D, 4'hF);
        chk("wr_rdy3_low", {31'd0, rdy3}, 32'd0);
        idle(4);
        chk("drain_rdy3", {31'd0, rdy3}, 32'd1);
        chk("drain_sv3", {31'd0, sv3}, 32'd0);
        rd(32'h4, 32'hCAFE_F00D);
        chk("thr_t1_rdy3", {31'd0, rdy3}, 32'd0);
        cyc();
        chk("thr_t2_rdy3", {31'd0, rdy3}, 32'd0);
        chk("thr_t2_sv3", {31'd0, sv3}, 32'd0);
        rd(32'h4, 32'hCAFE_F00D);
        chk("thr_t3_rdy3", {31'd0, rdy3}, 32'd0);
        chk("thr_sv3", {31'd0, sv3}, 32'd1);
        chk("thr_sv0", {31'd0, sv0}, 32'd0);
        chk("thr_rdy0", {31'd0, rdy0}, 32'd1);
        cyc();
        chk("thr_t4_rdy3", {31'd0, rdy3}, 32'd1);

        // Reset mid-throttle: async recovery, array retained.
        idle(2);
        rd(32'h4, 32'hCAFE_F00D);
        chk("prerst_rdy3", {31'd0, rdy3}, 32'd0);
        #2 HRESETn = 1'b0;
        #1;
        chk("rst_mid_rdy3", {31'd0, rdy3}, 32'd1);
        chk("rst_mid_sv3", {31'd0, sv3}, 32'd0);
        cyc();
        #2 HRESETn = 1'b1;
        cyc();
        rd(32'h4, 32'hCAFE_F00D);
        idle(4);

        // Basic write/read with no throttle.
        wr(32'h10, 32'hA5A5_5A5A, 4'hF);
        rd(32'h10, 32'hA5A5_5A5A);
        chk("basic_rdy0", {31'd0, rdy0}, 32'd1);
        chk("basic_sv3_sticky", {31'd0, sv3}, 32'd1);

        // Byte-lane write.
        wr(32'h10, 32'h1122_3344, 4'hF);
        wr(32'h10, 32'h00EE_0000, 4'b0100);
        rd(32'h10, 32'h11EE_3344);
        wr(32'h13, 32'h0000_0099, 4'b0000);
        rd(32'h10, 32'h11EE_3344);

        // Same-word collision.
        wr(32'h20, 32'h0, 4'hF);
`ifdef SRAM_RAW_FWD_EN
        coll_exp = 32'h0000_FFFF;
`else
        coll_exp = 32'h0000_0000;
`endif
        re = 1'b1; raddr = 32'h20;
        we = 1'b1; waddr = 32'h20; wdata = 32'hFFFF_FFFF; wsel = 4'h3;
        exp_q.push_back(coll_exp);
        cyc();
        we = 1'b0;
        rd(32'h20, 32'h0000_FFFF);

        // Different-word read and write in the same cycle.
        re = 1'b1; raddr = 32'h10;
        we = 1'b1; waddr = 32'h24; wdata = 32'h0BAD_BEEF; wsel = 4'hF;
        exp_q.push_back(32'h11EE_3344);
        cyc();
        we = 1'b0;
        rd(32'h24, 32'h0BAD_BEEF);

        // Out-of-range: 0x4000 would alias word 0 if high bits were ignored.
        wr(32'h0, 32'h1234_5678, 4'hF);
        wr(32'h4000, 32'hDEAD_DEAD, 4'hF);
        chk("oor_wr_aerr0", {31'd0, aerr0}, 32'd1);
        chk("oor_wr_aerr3", {31'd0, aerr3}, 32'd1);
        cyc();
        chk("oor_pulse_end", {31'd0, aerr0}, 32'd0);
        rd(32'h0, 32'h1234_5678);
        chk("inrange_aerr0", {31'd0, aerr0}, 32'd0);
        rd(32'h4000, 32'h0);
        chk("oor_rd_aerr0", {31'd0, aerr0}, 32'd1);
        idle(2);

        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d reads outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
